// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter for one shared single-cycle ALU. It grants round-robin,
// allows a bounded exclusive lock tenure and returns a registered, ID-tagged result.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_MAX   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid_i,
  input  logic                  req0_lock_i,
  input  logic [3:0]            req0_op_i,
  input  logic [DATA_WIDTH-1:0] req0_a_i,
  input  logic [DATA_WIDTH-1:0] req0_b_i,
  output logic                  req0_ready_o,
  input  logic                  req1_valid_i,
  input  logic                  req1_lock_i,
  input  logic [3:0]            req1_op_i,
  input  logic [DATA_WIDTH-1:0] req1_a_i,
  input  logic [DATA_WIDTH-1:0] req1_b_i,
  output logic                  req1_ready_o,
  output logic [3:0]            alu_op_o,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  alu_zero_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_id_o,
  output logic [DATA_WIDTH-1:0] rsp_result_o,
  output logic                  rsp_zero_o,
  output logic                  lock_active_o
);

  localparam int            CW         = $clog2(LOCK_MAX + 1);
  localparam logic [CW:0]   LOCK_MAX_C = (CW + 1)'(LOCK_MAX);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam bit            LOCK_EN    = (LOCK_MAX > 1);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    LOCKED0 = 2'd1,
    LOCKED1 = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [CW-1:0]   lock_count_q, lock_count_d;
  logic [CW:0]     count_inc;
  logic            grant0, grant1;
  logic            acc0, acc1, acc, acc_id, lock_sel;

  logic                  vld_p1;
  logic                  rsp_id_p1;
  logic [DATA_WIDTH-1:0] rsp_result_p1;
  logic                  rsp_zero_p1;

  // Grants are held low during reset so no request can be accepted then.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset) begin
      case (state_q)
        FREE: begin
          if (req0_valid_i && (!req1_valid_i || last_grant_q)) grant0 = 1'b1;
          else if (req1_valid_i)                               grant1 = 1'b1;
        end
        LOCKED0: grant0 = 1'b1;
        LOCKED1: grant1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign acc0     = grant0 & req0_valid_i;
  assign acc1     = grant1 & req1_valid_i;
  assign acc      = acc0 | acc1;
  assign acc_id   = acc1;
  assign lock_sel = grant1 ? req1_lock_i : req0_lock_i;

  assign count_inc = {1'b0, lock_count_q} + {{CW{1'b0}}, 1'b1};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_count_d = lock_count_q;
    if (acc) last_grant_d = acc_id;
    case (state_q)
      FREE: begin
        if (acc && lock_sel && LOCK_EN) begin
          state_d      = acc_id ? LOCKED1 : LOCKED0;
          lock_count_d = COUNT_ONE;
        end
      end
      LOCKED0, LOCKED1: begin
        // The tenure ends on an unlocked op, on reaching the op budget, or
        // when the owner goes idle and drops lock.
        if (acc) begin
          if (lock_sel && (count_inc < LOCK_MAX_C)) begin
            lock_count_d = count_inc[CW-1:0];
          end else begin
            state_d      = FREE;
            lock_count_d = '0;
          end
        end else if (!lock_sel) begin
          state_d      = FREE;
          lock_count_d = '0;
        end
      end
      default: begin
        state_d      = FREE;
        lock_count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= FREE;
      last_grant_q <= 1'b1;
      lock_count_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_count_q <= lock_count_d;
    end
  end

  // Stage p1: result captured from the shared ALU on accept
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p1        <= 1'b0;
      rsp_id_p1     <= 1'b0;
      rsp_result_p1 <= '0;
      rsp_zero_p1   <= 1'b0;
    end else begin
      vld_p1 <= acc;
      if (acc) begin
        rsp_id_p1     <= acc_id;
        rsp_result_p1 <= alu_result_i;
        rsp_zero_p1   <= alu_zero_i;
      end
    end
  end

  always_comb begin
    alu_op_o = 4'b0000;
    alu_a_o  = '0;
    alu_b_o  = '0;
    if (grant0) begin
      alu_op_o = req0_op_i;
      alu_a_o  = req0_a_i;
      alu_b_o  = req0_b_i;
    end else if (grant1) begin
      alu_op_o = req1_op_i;
      alu_a_o  = req1_a_i;
      alu_b_o  = req1_b_i;
    end
  end

  assign req0_ready_o  = grant0;
  assign req1_ready_o  = grant1;
  assign rsp_valid_o   = vld_p1;
  assign rsp_id_o      = rsp_id_p1;
  assign rsp_result_o  = rsp_result_p1;
  assign rsp_zero_o    = rsp_zero_p1;
  assign lock_active_o = (state_q == LOCKED0) || (state_q == LOCKED1);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed stimulus pushes expected
// responses, a negedge monitor pops and compares them against rsp_* outputs.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid_i, req0_lock_i, req1_valid_i, req1_lock_i;
  logic [3:0]  req0_op_i, req1_op_i;
  logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic        req0_ready_o, req1_ready_o;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_a_o, alu_b_o, alu_result_i;
  logic        alu_zero_i;
  logic        rsp_valid_o, rsp_id_o, rsp_zero_o, lock_active_o;
  logic [31:0] rsp_result_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          stamp;
    logic        id;
    logic [31:0] res;
    logic        zero;
  } exp_t;
  exp_t sbq[$];

  alu_share_arbiter #(.DATA_WIDTH(32), .LOCK_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid_i(req0_valid_i), .req0_lock_i(req0_lock_i), .req0_op_i(req0_op_i),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_lock_i(req1_lock_i), .req1_op_i(req1_op_i),
    .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_ready_o(req1_ready_o),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_result_o(rsp_result_o),
    .rsp_zero_o(rsp_zero_o), .lock_active_o(lock_active_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // External ALU: 0 add, 1 sub, 2 and, 3 or, otherwise xor.
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result_i = alu_model(alu_op_o, alu_a_o, alu_b_o);
  assign alu_zero_i   = (alu_result_i == 32'd0);

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic set0(input logic v, input logic l, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_valid_i = v; req0_lock_i = l; req0_op_i = op; req0_a_i = a; req0_b_i = b;
  endtask

  task automatic set1(input logic v, input logic l, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req1_valid_i = v; req1_lock_i = l; req1_op_i = op; req1_a_i = a; req1_b_i = b;
  endtask

  task automatic push(input logic id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.stamp = cyc;
    e.id    = id;
    e.res   = alu_model(op, a, b);
    e.zero  = (e.res == 32'd0);
    sbq.push_back(e);
  endtask

  // One cycle: inputs already driven; check grant/ports, record expected accept.
  task automatic step(input logic eg0, input logic eg1, input logic elock);
    logic [3:0]  op;
    logic [31:0] a, b;
    #1;
    chk("ready0", req0_ready_o, eg0);
    chk("ready1", req1_ready_o, eg1);
    chk("lock_active", lock_active_o, elock);
    op = 4'b0000; a = '0; b = '0;
    if (eg0)      begin op = req0_op_i; a = req0_a_i; b = req0_b_i; end
    else if (eg1) begin op = req1_op_i; a = req1_a_i; b = req1_b_i; end
    chk("alu_ports", {alu_op_o, alu_a_o, alu_b_o}, {op, a, b});
    if (eg0 && req0_valid_i)      push(1'b0, op, a, b);
    else if (eg1 && req1_valid_i) push(1'b1, op, a, b);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0 && sbq[0].stamp < cyc) begin
      e = sbq.pop_front();
      chk("rsp_valid", rsp_valid_o, 1'b1);
      chk("rsp_id", rsp_id_o, e.id);
      chk("rsp_result", rsp_result_o, e.res);
      chk("rsp_zero", rsp_zero_o, e.zero);
    end else begin
      chk("rsp_valid_idle", rsp_valid_o, 1'b0);
    end
  end

  initial begin
    reset = 1'b0;
    set0(1, 0, 4'b0000, 32'd11, 32'd22);
    set1(1, 0, 4'b0001, 32'd33, 32'd44);
    @(posedge clk);
    #1;
    // Reset held with both valid: nothing granted, ALU ports idle.
    step(0, 0, 0);
    step(0, 0, 0);
    chk("reset_rsp", {rsp_valid_o, rsp_id_o, rsp_zero_o, rsp_result_o}, 35'd0);

    // Release with both valid: req0 first, then strict alternation.
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set0(1, 0, 4'b0000, 32'(i * 3), 32'd100);
      set1(1, 0, 4'b0001, 32'd50, 32'(i));
      step(i % 2 == 0, i % 2 == 1, 0);
    end

    // Single op from req0: 5 + 7 = 12, then a gap.
    set0(0, 0, 4'b0000, 32'd0, 32'd0);
    set1(0, 0, 4'b0000, 32'd0, 32'd0);
    step(0, 0, 0);
    set0(1, 0, 4'b0000, 32'd5, 32'd7);
    step(1, 0, 0);
    chk("single_valid", rsp_valid_o, 1'b1);
    chk("single_id", rsp_id_o, 1'b0);
    chk("single_result", rsp_result_o, 32'd12);
    chk("single_zero", rsp_zero_o, 1'b0);
    set0(0, 0, 4'b0000, 32'd0, 32'd0);
    step(0, 0, 0);
    chk("single_gap", rsp_valid_o, 1'b0);

    // req1 holds a lock for three ops, releases on the fourth; req0 waits.
    for (int i = 0; i < 4; i++) begin
      set0(1, 0, 4'b0010, 32'hFFFF_0000, 32'h1234_5678);
      set1(1, i < 3, 4'b0001, (i == 2) ? 32'd9 : 32'(20 + i), (i == 2) ? 32'd9 : 32'd3);
      step(0, 1, i >= 1);
    end
    set1(1, 0, 4'b0100, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
    step(1, 0, 0);
    set0(0, 0, 4'b0000, 32'd0, 32'd0);
    step(0, 1, 0);

    // req0 locks continuously: forced release after 8 ops, req1 gets one, req0 re-locks.
    for (int c = 1; c <= 12; c++) begin
      set0(1, 1, 4'b0010, 32'hF0F0_0000 | 32'(c), 32'h00FF_FFFF);
      set1(1, 0, 4'b0011, 32'(c), 32'h100);
      step(c != 9, c == 9, ((c >= 2) && (c <= 8)) || (c >= 11));
    end
    // Owner goes idle without lock: stays ready this cycle, then releases.
    set0(0, 0, 4'b0000, 32'd0, 32'd0);
    step(1, 0, 1);

    // req1 locks, idles with lock held, accepts again, then reset hits.
    set0(1, 0, 4'b0000, 32'd1, 32'd1);
    set1(1, 1, 4'b0000, 32'd40, 32'd2);
    step(0, 1, 0);
    set1(0, 1, 4'b0000, 32'd0, 32'd0);
    step(0, 1, 1);
    set1(1, 1, 4'b0001, 32'd40, 32'd2);
    step(0, 1, 1);
    reset = 1'b0;
    step(0, 0, 1);
    reset = 1'b1;
    chk("midlock_rsp_valid", rsp_valid_o, 1'b0);
    set0(1, 0, 4'b0011, 32'h8000_0000, 32'd1);
    set1(1, 0, 4'b0000, 32'd2, 32'd2);
    step(1, 0, 0);

    set0(0, 0, 4'b0000, 32'd0, 32'd0);
    set1(0, 0, 4'b0000, 32'd0, 32'd0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("sb_drain", 96'(sbq.size()), 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
